// File: rtl/alarm_switch_ctrl.sv
// Front-panel switch controller: two-flop synchroniser, per-switch debounce, edge capture with
// W1C clear, and a maskable level interrupt behind a 4-word Avalon-MM slave.
module alarm_switch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [1:0]  in_port,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       irqmask_q, irqmask_d;
   logic [1:0]       edgecap_q, edgecap_d;
   logic [1:0]       polarity_q, polarity_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [1:0]       cap_set, cap_clr;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata[31:2];
   assign wr_en        = chipselect & ~write_n;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      cap_set  = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
            // Polarity 0 captures a new level of 1, polarity 1 a new level of 0.
            cap_set[i]  = sync2_q[i] ^ polarity_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      irqmask_d  = irqmask_q;
      polarity_d = polarity_q;
      cap_clr    = '0;
      if (wr_en) begin
         case (address)
            2'd1:    irqmask_d  = writedata[1:0];
            2'd2:    cap_clr    = writedata[1:0];
            2'd3:    polarity_d = writedata[1:0];
            default: ;
         endcase
      end
      // A capture on the same edge as its clear must survive.
      edgecap_d = (edgecap_q & ~cap_clr) | cap_set;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[1:0] = stable_q;
         2'd1:    readdata_d[1:0] = irqmask_q;
         2'd2:    readdata_d[1:0] = edgecap_q;
         default: readdata_d[1:0] = polarity_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         cnt_q      <= '{default: '0};
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         polarity_q <= '0;
         readdata_q <= '0;
      end else begin
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         cnt_q      <= cnt_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         polarity_q <= polarity_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: doc/alarm_switch_ctrl.md
# alarm_switch_ctrl

Debounce and edge-interrupt controller for the alarm clock's two front-panel slide switches, sitting between the raw `in_port` pins and the Nios II Avalon-MM bus. It synchronises and debounces each switch, holds a stable level register, latches configurable edges into a write-1-to-clear capture register and raises a maskable interrupt. Firmware reads clean switch state and services alarm-set/snooze changes by interrupt instead of polling.

## Interface
- `DEBOUNCE_CYCLES`, 50000, consecutive cycles a synchronised input must differ from the stable level before the stable level changes (1 ms at 50 MHz); legal range ≥ 2
- `CNT_W`, 16, debounce counter width; must hold `DEBOUNCE_CYCLES-1`
- `clk`  in  1  system clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  2  Avalon-MM word offset
- `chipselect`  in  1  slave select; qualifies writes
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  registered read data
- `in_port`  in  2  raw asynchronous switch inputs
- `irq`  out  1  level interrupt, active high

## Operation
- Register map (unused bits read 0, writes to them ignored):
  - 0 DATA (RO): bits[1:0] debounced stable level; writes ignored
  - 1 IRQMASK (RW): bits[1:0] per-switch interrupt enable
  - 2 EDGECAP (R/W1C): bits[1:0] captured edges; writing 1 clears bit, 0 leaves it
  - 3 POLARITY (RW): bits[1:0]; 0 = capture rising (off→on), 1 = capture falling
- Synchroniser: two flops per bit, `sync1 <= in_port`, `sync2 <= sync1`.
- Debounce, per bit, independent counter `cnt`:
  - `sync2 == stable`: `cnt <= 0`
  - `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`
  - `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`
  - any glitch back to `stable` before terminal count restarts counting from 0
- Edge capture: on the clock edge where `stable[i]` updates, `edgecap[i] <= 1` if new level is 1 with `polarity[i]=0`, or new level is 0 with `polarity[i]=1`.
- Simultaneous W1C clear and new capture on same bit, same cycle: set wins (bit stays 1).
- `irq = |(edgecap & irqmask)`, combinational from registers; asserts/deasserts with no extra delay after those registers change.
- Writing IRQMASK or POLARITY never modifies EDGECAP; polarity change affects only subsequent stable transitions.
- Reads have no side effects; `readdata` updates every cycle from `address` regardless of `chipselect`.

## Timing
- Reset (async assert, sync release by system): `sync1`, `sync2`, `stable`, `cnt`, IRQMASK, EDGECAP, POLARITY = 0; `readdata` = 0; `irq` = 0.
- Switch held high through reset: debounces to 1 after release and captures a rising edge (POLARITY=0) — intended, firmware clears EDGECAP at init.
- Input step settled before edge 0: `sync2` changes at edge 2, `stable` and `edgecap` update at edge 2+`DEBOUNCE_CYCLES`, `irq` high immediately after that edge if masked in.
- Read latency 1: `readdata` at edge N reflects `address` and register contents sampled at edge N; DATA change visible on `readdata` at edge 3+`DEBOUNCE_CYCLES`.
- Write takes effect at the edge where `chipselect=1`, `write_n=0`; read of same register next cycle returns new value one edge later.
- Reset mid-debounce discards partial count; no capture generated.

## Test plan
- Reset values: assert `reset_n`=0 mid-cycle -> all four registers read 0, `irq`=0, `readdata`=0 asynchronously.
- Clean step, `DEBOUNCE_CYCLES`=4: `in_port` 00→01 before edge 0 -> `stable[0]`=1 and EDGECAP=01 at edge 6, DATA reads 0x1 at edge 7; IRQMASK=01 -> `irq`=1 after edge 6; IRQMASK=00 -> `irq` stays 0.
- Bounce rejection, D=4: bit 1 toggles high for 3 cycles then low, repeated 5 times, then high steady -> DATA bit 1 stays 0 during bounce, becomes 1 exactly 2+4 edges after final settle; only one EDGECAP set.
- Polarity: POLARITY=10, switch 1 goes 1→0 after being debounced high -> EDGECAP=10; rising edge on switch 1 afterwards -> no new capture.
- W1C and collision: EDGECAP=11, write 0x1 to offset 2 -> reads 10, `irq` follows mask; W1C of bit 0 on same edge as new bit-0 capture -> bit 0 reads 1.
- Write ignore and independence: write 0xFFFFFFFF to offset 0 -> DATA unchanged; write offset 1 = 0xFFFFFFFF -> reads 0x3; both switches toggle same cycle -> both capture at same edge.
